// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback stage: opcodes, FSM encoding, size defaults.
package alu_issue_ctrl_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int NREG_DEF  = 4;
   localparam int AW_DEF    = 2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// NREG x WIDTH register file: three asynchronous read ports, one synchronous write port,
// synchronous active-low clear.
module alu_regfile
   import alu_issue_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREG  = NREG_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_a_i,
   output logic [WIDTH-1:0] rdata_a_o,
   input  logic [AW-1:0]    raddr_b_i,
   output logic [WIDTH-1:0] rdata_b_o,
   input  logic [AW-1:0]    raddr_d_i,
   output logic [WIDTH-1:0] rdata_d_o
);

   logic [WIDTH-1:0] regs_q [NREG];

   // Reads return the stored value, so a read in the cycle of a write sees the old contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];
   assign rdata_d_o = regs_q[raddr_d_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around an external combinational ALU: accepts one instruction at a time,
// feeds the ALU from the register file for one EXEC cycle and writes the result back.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREG  = NREG_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_ld,
   input  logic [1:0]       in_opcode,
   input  logic [AW-1:0]    in_rd,
   input  logic [AW-1:0]    in_rs1,
   input  logic [AW-1:0]    in_rs2,
   input  logic [WIDTH-1:0] in_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             done,
   output logic             zero_flag,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   state_e           state_q;
   logic [AW-1:0]    rd_q, rs1_q, rs2_q;
   logic [1:0]       op_q;
   logic             zero_q, done_q;

   logic             xfer, exec;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rs1_data, rs2_data;

   assign in_ready = (state_q == ST_IDLE);
   assign exec     = (state_q == ST_EXEC);
   assign xfer     = in_valid & in_ready;

   // Loads write at the accepting edge; ALU results write at the end of EXEC.
   assign wr_en   = exec | (xfer & in_ld);
   assign wr_addr = exec ? rd_q : in_rd;
   assign wr_data = exec ? alu_result : in_imm;

   alu_regfile #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (wr_en),
      .waddr_i   (wr_addr),
      .wdata_i   (wr_data),
      .raddr_a_i (rs1_q),
      .rdata_a_o (rs1_data),
      .raddr_b_i (rs2_q),
      .rdata_b_o (rs2_data),
      .raddr_d_i (dbg_addr),
      .rdata_d_o (dbg_data)
   );

   assign alu_a  = exec ? rs1_data : '0;
   assign alu_b  = exec ? rs2_data : '0;
   assign alu_op = exec ? op_q : OP_ADD;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= xfer & in_ld;
               if (xfer && !in_ld) begin
                  rd_q    <= in_rd;
                  rs1_q   <= in_rs1;
                  rs2_q   <= in_rs2;
                  op_q    <= in_opcode;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               zero_q  <= alu_zero;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign done      = done_q;
   assign zero_flag = zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized and directed bench for alu_issue_ctrl against an instruction-level register model.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   localparam int WIDTH = 4;
   localparam int NREG  = 4;
   localparam int AW    = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ld = 1'b0;
   logic [1:0]       in_opcode = '0;
   logic [AW-1:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0, dbg_addr = '0;
   logic [WIDTH-1:0] in_imm = '0;
   logic             in_ready, alu_zero, done, zero_flag;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result, dbg_data;
   logic [1:0]       alu_op;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int exp_done = 0;

   logic [WIDTH-1:0] m_regs [NREG];
   logic             m_zero;

   alu_issue_ctrl #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ld      (in_ld),
      .in_opcode  (in_opcode),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_imm     (in_imm),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .done       (done),
      .zero_flag  (zero_flag),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         default: return a | b;
      endcase
   endfunction

   // Stand-in for the external combinational ALU.
   always_comb begin
      alu_result = alu_fn(alu_op, alu_a, alu_b);
      alu_zero   = (alu_result == '0);
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reg(input int a);
      dbg_addr = AW'(a);
      #1;
      chk($sformatf("reg%0d", a), 32'(dbg_data), 32'(m_regs[a]));
   endtask

   task automatic model_clear();
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_zero = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_clear();
   endtask

   task automatic drive(input logic ld, input logic [1:0] op, input int rd, input int rs1,
                        input int rs2, input logic [WIDTH-1:0] imm);
      in_valid  = 1'b1;
      in_ld     = ld;
      in_opcode = op;
      in_rd     = AW'(rd);
      in_rs1    = AW'(rs1);
      in_rs2    = AW'(rs2);
      in_imm    = imm;
   endtask

   // Issues one instruction, then checks EXEC-cycle ALU drive and the retirement against the model.
   task automatic issue(input logic ld, input logic [1:0] op, input int rd, input int rs1,
                        input int rs2, input logic [WIDTH-1:0] imm);
      int w;
      logic [WIDTH-1:0] res;
      drive(ld, op, rd, rs1, rs2, imm);
      w = 0;
      while (!in_ready && w < 10) begin
         @(posedge clk); #1; w++;
      end
      if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (ld) begin
         m_regs[rd] = imm;
         exp_done++;
         chk("ld_done", 32'(done), 32'd1);
         chk("ld_zf", 32'(zero_flag), 32'(m_zero));
         check_reg(rd);
      end else begin
         chk("ex_ready", 32'(in_ready), 32'd0);
         chk("ex_nodone", 32'(done), 32'd0);
         chk("alu_a", 32'(alu_a), 32'(m_regs[rs1]));
         chk("alu_b", 32'(alu_b), 32'(m_regs[rs2]));
         chk("alu_op", 32'(alu_op), 32'(op));
         res = alu_fn(op, m_regs[rs1], m_regs[rs2]);
         @(posedge clk);
         #1;
         m_regs[rd] = res;
         m_zero = (res == '0);
         exp_done++;
         chk("ex_done", 32'(done), 32'd1);
         chk("ex_zf", 32'(zero_flag), 32'(m_zero));
         chk("ex_idle_alu_a", 32'(alu_a), 32'd0);
         check_reg(rd);
      end
   endtask

   task automatic settle();
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("done_count", 32'(done_cnt), 32'(exp_done));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      // 1. reset state
      do_reset();
      for (int a = 0; a < NREG; a++) check_reg(a);
      chk("rst_zf", 32'(zero_flag), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);

      // 2. loads then ADD
      issue(1'b1, OP_ADD, 1, 0, 0, 4'b0101);
      issue(1'b1, OP_ADD, 2, 0, 0, 4'b0011);
      issue(1'b0, OP_ADD, 3, 1, 2, 4'h0);
      chk("t2_r3", 32'(m_regs[3]), 32'b1000);
      settle();

      // 3. SUB to zero, then a load keeps the flag
      issue(1'b0, OP_SUB, 0, 2, 2, 4'h0);
      chk("t3_zf", 32'(zero_flag), 32'd1);
      issue(1'b1, OP_ADD, 3, 0, 0, 4'b0110);
      chk("t3_zf_kept", 32'(zero_flag), 32'd1);
      settle();

      // 4. AND / OR / wrapping ADD
      issue(1'b1, OP_ADD, 1, 0, 0, 4'b1100);
      issue(1'b1, OP_ADD, 2, 0, 0, 4'b1010);
      issue(1'b1, OP_ADD, 3, 0, 0, 4'b1111);
      issue(1'b0, OP_AND, 0, 1, 2, 4'h0);
      chk("t4_and", 32'(m_regs[0]), 32'b1000);
      issue(1'b0, OP_OR, 1, 3, 0, 4'h0);
      chk("t4_or", 32'(m_regs[1]), 32'b1111);
      issue(1'b1, OP_ADD, 2, 0, 0, 4'b0001);
      issue(1'b0, OP_ADD, 0, 3, 2, 4'h0);
      chk("t4_wrap_zf", 32'(zero_flag), 32'd1);
      settle();

      // 5. in_valid held through EXEC while fields change
      drive(1'b0, OP_SUB, 3, 1, 2, 4'h0);
      @(posedge clk);
      #1 drive(1'b1, OP_ADD, 2, 0, 0, 4'b0111);
      chk("t5_ready_exec", 32'(in_ready), 32'd0);
      chk("t5_alu_op", 32'(alu_op), 32'(OP_SUB));
      m_regs[3] = alu_fn(OP_SUB, m_regs[1], m_regs[2]);
      m_zero = (m_regs[3] == '0);
      exp_done++;
      @(posedge clk);
      #1;
      chk("t5_ready_idle", 32'(in_ready), 32'd1);
      chk("t5_done_alu", 32'(done), 32'd1);
      check_reg(2);
      check_reg(3);
      @(posedge clk);
      #1 in_valid = 1'b0;
      m_regs[2] = 4'b0111;
      exp_done++;
      chk("t5_done_ld", 32'(done), 32'd1);
      check_reg(2);
      settle();

      // 6. reset during EXEC drops the writeback
      issue(1'b1, OP_ADD, 1, 0, 0, 4'b0010);
      issue(1'b1, OP_ADD, 2, 0, 0, 4'b0100);
      settle();
      drive(1'b0, OP_ADD, 3, 1, 2, 4'h0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_clear();
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_ready", 32'(in_ready), 32'd1);
      chk("t6_zf", 32'(zero_flag), 32'd0);
      for (int a = 0; a < NREG; a++) check_reg(a);
      settle();
      issue(1'b1, OP_ADD, 1, 0, 0, 4'b0011);
      issue(1'b0, OP_ADD, 3, 1, 1, 4'h0);
      chk("t6_after", 32'(m_regs[3]), 32'b0110);
      settle();

      // randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         issue(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
               int'($urandom_range(0, NREG-1)), int'($urandom_range(0, NREG-1)),
               int'($urandom_range(0, NREG-1)), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      settle();
      for (int a = 0; a < NREG; a++) check_reg(a);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
